// File: rtl/letter_input.sv
// letter_input: PS/2 keyboard receiver and letter decoder.
//   Receives PS/2 frames (start, 8 data bits LSB first, odd parity, stop),
//   decodes set-2 make codes for A..Z and Enter, suppresses typematic
//   repeats and break/extended sequences.
// Ports:
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   load       one-cycle pulse, new letter/start code on load_x
//   load_x     0..25 = A..Z, 26 = Enter; holds until the next load
//   frame_err  one-cycle pulse on parity/stop error or frame timeout
module letter_input #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       load,
    output logic [4:0] load_x,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    // 31 marks both "no key held" and "code not in the table".
    localparam logic [4:0] CODE_NONE = 5'd31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Set-2 make code to letter index; CODE_NONE for anything unmapped.
    function automatic logic [4:0] map_code(input logic [7:0] b);
        logic [4:0] r;
        case (b)
            8'h1C: r = 5'd0;   8'h32: r = 5'd1;   8'h21: r = 5'd2;
            8'h23: r = 5'd3;   8'h24: r = 5'd4;   8'h2B: r = 5'd5;
            8'h34: r = 5'd6;   8'h33: r = 5'd7;   8'h43: r = 5'd8;
            8'h3B: r = 5'd9;   8'h42: r = 5'd10;  8'h4B: r = 5'd11;
            8'h3A: r = 5'd12;  8'h31: r = 5'd13;  8'h44: r = 5'd14;
            8'h4D: r = 5'd15;  8'h15: r = 5'd16;  8'h2D: r = 5'd17;
            8'h1B: r = 5'd18;  8'h2C: r = 5'd19;  8'h3C: r = 5'd20;
            8'h2A: r = 5'd21;  8'h1D: r = 5'd22;  8'h22: r = 5'd23;
            8'h35: r = 5'd24;  8'h1A: r = 5'd25;  8'h5A: r = 5'd26;
            default: r = CODE_NONE;
        endcase
        return r;
    endfunction

    // Odd parity over data plus parity bit.
    function automatic logic parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic [4:0]    last_q, last_d;
    logic          load_q, load_d;
    logic [4:0]    load_x_q, load_x_d;
    logic          err_q, err_d;
    logic          fall_s;
    logic [4:0]    code_s;

    assign fall_s    = clk_prev_q & ~clk_sync_q;
    assign code_s    = map_code(shift_q);
    assign load      = load_q;
    assign load_x    = load_x_q;
    assign frame_err = err_q;

    // Next-state logic: frame reception, timeout and key decoding.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        last_d    = last_q;
        load_d    = 1'b0;
        load_x_d  = load_x_q;
        err_d     = 1'b0;
        if (fall_s) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                        shift_d   = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shift_d = {dat_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_d   = dat_sync_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    if (dat_sync_q && parity_ok(shift_q, par_q)) begin
                        if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (brk_q || ext_q) begin
                            // Tail of a break/extended sequence: swallow it.
                            if (brk_q) begin
                                last_d = CODE_NONE;
                            end else begin
                                last_d = last_q;
                            end
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end else if (code_s != CODE_NONE && code_s != last_q) begin
                            load_d   = 1'b1;
                            load_x_d = code_s;
                            last_d   = code_s;
                        end else begin
                            // Unmapped code or typematic repeat: no output.
                            last_d = last_q;
                        end
                    end else begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                // Keyboard went silent mid-frame: drop everything.
                state_d   = IDLE;
                bit_cnt_d = 3'd0;
                shift_d   = 8'd0;
                tmo_d     = '0;
                err_d     = 1'b1;
                brk_d     = 1'b0;
                ext_d     = 1'b0;
                last_d    = CODE_NONE;
            end else begin
                tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            tmo_d = '0;
        end
    end

    // State registers, input synchronizers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            last_q     <= CODE_NONE;
            load_q     <= 1'b0;
            load_x_q   <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            last_q     <= last_d;
            load_q     <= load_d;
            load_x_q   <= load_x_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_letter_input.sv
// Randomized bench for letter_input with a behavioural keyboard model.
module tb_letter_input;

    localparam int T = 300;   // timeout used for the DUT instance
    localparam int H = 4;     // PS/2 half-bit phase length in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       load;
    logic [4:0] load_x;
    logic       frame_err;

    letter_input #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .load(load), .load_x(load_x), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [4:0] x;
        int         due;
    } ev_t;
    ev_t ev_q[$];

    int checks = 0;
    int errors = 0;
    int n_load = 0;
    int n_err  = 0;
    logic [4:0] exp_x = 5'd0;
    int last_c0 = 0;

    // Behavioural keyboard state.
    bit m_brk = 1'b0;
    bit m_ext = 1'b0;
    int m_last = -1;
    logic [7:0] codes [27] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h5A};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model's event list.
    always @(negedge clk) begin
        logic el, ee;
        el = 1'b0;
        ee = 1'b0;
        if (!reset) begin
            ev_q.delete();
            exp_x = 5'd0;
        end else if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
            if (ev_q[0].is_err) begin
                ee = 1'b1;
            end else begin
                el = 1'b1;
                exp_x = ev_q[0].x;
            end
            void'(ev_q.pop_front());
        end
        if (load === 1'b1) n_load++;
        if (frame_err === 1'b1) n_err++;
        checks++;
        if (load !== el || frame_err !== ee || load_x !== exp_x) begin
            errors++;
            $display("FAIL cycle %0d outputs: load=%b err=%b x=%0d, expected load=%b err=%b x=%0d",
                     cyc, load, frame_err, load_x, el, ee, exp_x);
        end
    end

    // Apply the keyboard rules to one received frame ending at cycle c0.
    task automatic model_frame(input logic [7:0] b, input bit ok, input int c0);
        int idx;
        ev_t e;
        if (!ok) begin
            e.is_err = 1'b1; e.x = 5'd0; e.due = c0 + 3;
            ev_q.push_back(e);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (m_brk || m_ext) begin
            if (m_brk) m_last = -1;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            idx = -1;
            for (int i = 0; i < 27; i++) if (codes[i] == b) idx = i;
            if (idx >= 0 && idx != m_last) begin
                e.is_err = 1'b0; e.x = 5'(idx); e.due = c0 + 3;
                ev_q.push_back(e);
                m_last = idx;
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk) ps2_data = v;
        repeat (H - 1) @(negedge clk);
        ps2_clk = 1'b0;
        last_c0 = cyc;
    endtask

    task automatic release_clk();
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit badp, input bit bads);
        logic [10:0] bits;
        bits = {~bads, (~(^b)) ^ badp, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive_bit(bits[i]);
            if (i == 10) model_frame(b, !badp && !bads, last_c0);
            release_clk();
        end
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Start bit plus n data bits, then silence until the timeout fires.
    task automatic send_partial(input logic [7:0] b, input int n);
        ev_t e;
        drive_bit(1'b0);
        release_clk();
        for (int i = 0; i < n; i++) begin
            drive_bit(b[i]);
            release_clk();
        end
        ps2_data = 1'b1;
        e.is_err = 1'b1; e.x = 5'd0; e.due = last_c0 + T + 3;
        ev_q.push_back(e);
        m_brk = 1'b0;
        m_ext = 1'b0;
        m_last = -1;
        repeat (T + 10) @(negedge clk);
    endtask

    initial begin
        int l0, e0, r, n;
        logic [7:0] b, prev;
        repeat (3) @(negedge clk);
        #1;
        check("reset load", int'(load), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset load_x", int'(load_x), 0);
        @(negedge clk) reset = 1'b1;
        repeat (10) @(negedge clk);

        l0 = n_load;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("1C loads", n_load - l0, 1);
        check("1C load_x", int'(load_x), 0);

        l0 = n_load;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        check("enter loads", n_load - l0, 1);
        check("enter load_x", int'(load_x), 26);

        l0 = n_load;
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        check("typematic loads", n_load - l0, 2);
        check("typematic load_x", int'(load_x), 4);

        l0 = n_load; e0 = n_err;
        send_frame(8'h15, 1'b1, 1'b0);
        check("parity err count", n_err - e0, 1);
        check("parity err loads", n_load - l0, 0);
        send_frame(8'h15, 1'b0, 1'b0);
        check("Q load_x", int'(load_x), 16);

        e0 = n_err;
        send_partial(8'h55, 3);
        check("timeout err count", n_err - e0, 1);
        send_frame(8'h1A, 1'b0, 1'b0);
        check("Z load_x", int'(load_x), 25);

        l0 = n_load;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h76, 1'b0, 1'b0);
        check("ext/esc loads", n_load - l0, 0);

        // Reset in the middle of a 0x32 frame.
        l0 = n_load;
        drive_bit(1'b0);
        release_clk();
        drive_bit(1'b0);
        release_clk();
        drive_bit(1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset load_x", int'(load_x), 0);
        check("midreset frame_err", int'(frame_err), 0);
        m_brk = 1'b0; m_ext = 1'b0; m_last = -1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset loads", n_load - l0, 0);
        send_frame(8'h32, 1'b0, 1'b0);
        check("B after reset", int'(load_x), 1);

        prev = 8'h1C;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) b = codes[$urandom_range(0, 26)];
            else if (r == 6) b = 8'hF0;
            else if (r == 7) b = 8'hE0;
            else if (r == 8) b = 8'($urandom);
            else b = prev;
            prev = b;
            n = $urandom_range(0, 19);
            if (n == 0) send_partial(b, $urandom_range(0, 7));
            else send_frame(b, n == 1, n == 2);
        end

        repeat (20) @(negedge clk);
        check("pending events", ev_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/letter_input.md
LETTER_INPUT -- requirements
Module: letter_input

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the maximum clk cycles allowed between PS/2 clock falling edges inside a frame.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ps2_clk  input  1  raw PS/2 keyboard clock, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 keyboard data, asynchronous to clk.
REQ-006 load  output  1  one-cycle pulse: a new guess or start command is on load_x.
REQ-007 load_x  output  5  letter index 0..25 (A..Z), or 26 for Enter (start game).
REQ-008 frame_err  output  1  one-cycle pulse: a received frame had a parity or stop-bit error, or timed out.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is a synchronized 1 followed by 0 on consecutive clk cycles.
REQ-010 Receiver FSM states: IDLE, DATA, PARITY, STOP; all sampling on detected falling edges only.
REQ-011 IDLE: data 0 at an edge -> DATA with bit count 0; data 1 -> stay IDLE, no output.
REQ-012 DATA: shift in 8 bits LSB first; after the 8th -> PARITY.
REQ-013 PARITY: capture bit -> STOP; the 8 data bits plus parity SHALL have odd total of ones.
REQ-014 STOP: stop bit 1 and parity good -> byte valid; otherwise frame_err pulses; either way -> IDLE.
REQ-015 Timeout counter resets on every edge; in DATA/PARITY/STOP, reaching TIMEOUT_CYCLES with no edge -> IDLE, frame_err pulses, partial byte discarded, decoder flags cleared.
REQ-016 Decoder flags: brk (after 0xF0), ext (after 0xE0), last_make (5-bit code of held key, or none).
REQ-017 Valid 0xF0: set brk, no output. Valid 0xE0: set ext, no output.
REQ-018 Valid other byte with brk or ext set: clear both flags, clear last_make if brk was set, no output.
REQ-019 Valid other byte with no flags: map via set-2 table A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A -> 0..25; Enter 5A -> 26; any other code -> no output, flags unchanged.
REQ-020 Typematic suppression: mapped code equal to last_make -> no output; else emit and set last_make to it.
REQ-021 Emit: load high exactly one cycle, in the cycle after the stop-bit edge is detected; load_x updates the same cycle and holds until the next emit.
REQ-022 Parity/stop error SHALL clear brk and ext but leave last_make unchanged.
REQ-023 load and frame_err SHALL never be high in the same cycle; at most one load per frame.
REQ-024 ps2_data stuck low in IDLE yields at most one start detection per edge and no output without a complete frame.

Reset
REQ-025 reset low SHALL immediately force: FSM IDLE, bit count 0, shift register 0, timeout counter 0, brk=ext=0, last_make none, load=0, load_x=0, frame_err=0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame discards the partial frame; the first frame starting after reset release decodes normally.
REQ-027 Reset release SHALL NOT itself produce a load or frame_err pulse.

Verification
REQ-028 Frame 0x1C (parity 0, stop 1) -> one load pulse, load_x=0, frame_err=0.
REQ-029 Frames 0x5A, F0, 5A -> one load with load_x=26, no second pulse for the break sequence.
REQ-030 Frames 0x24, 0x24, 0x24 (held E), F0, 24, then 0x24 -> exactly two loads, load_x=4 each.
REQ-031 Frame 0x15 with parity bit 1 -> frame_err one cycle, no load; next good 0x15 -> load_x=16.
REQ-032 Start bit plus 3 data bits then no edges for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; following 0x1A -> load_x=25.
REQ-033 Frames E0, 75 (arrow), then 0x76 (Esc) -> no load; reset low during a 0x32 frame -> all outputs 0, no load for that frame.
